// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core front end: reset/exception vectors,
// the bubble encoding and the next-PC source selector.
package cpu_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;
    localparam logic [31:0] NOP_INST   = 32'h0000_0000;

    typedef enum logic [2:0] {
        PC_SEQ,
        PC_HOLD,
        PC_BR,
        PC_JR,
        PC_JMP,
        PC_EXC
    } pc_sel_e;

    function automatic logic word_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: priority encodes the redirect sources,
// checks target alignment and reports whether the fetched word is wrong-path.
module next_pc_sel
    import cpu_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus4_i,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_target_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    input  logic        exc_i,
    output logic [31:0] next_pc_o,
    output logic        redirect_o,
    output logic        misalign_o
);

    pc_sel_e     sel;
    logic [31:0] raw_target;

    always_comb begin
        sel = PC_SEQ;
        if (exc_i)           sel = PC_EXC;
        else if (br_taken_i) sel = PC_BR;
        else if (jr_i)       sel = PC_JR;
        else if (jmp_i)      sel = PC_JMP;
        else if (stall_i)    sel = PC_HOLD;
    end

    always_comb begin
        raw_target = pc_plus4_i;
        case (sel)
            PC_SEQ:  raw_target = pc_plus4_i;
            PC_HOLD: raw_target = pc_i;
            PC_BR:   raw_target = br_target_i;
            PC_JR:   raw_target = jr_target_i;
            PC_JMP:  raw_target = jmp_target_i;
            PC_EXC:  raw_target = EXC_VECTOR;
            default: raw_target = pc_plus4_i;
        endcase
    end

    // Any redirect (even one that stall would otherwise block) invalidates
    // the word currently being fetched; a misaligned target traps instead.
    assign redirect_o = (sel == PC_EXC) || (sel == PC_BR) ||
                        (sel == PC_JR)  || (sel == PC_JMP);
    assign misalign_o = redirect_o && word_misaligned(raw_target);
    assign next_pc_o  = misalign_o ? EXC_VECTOR : raw_target;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, fetch address to the combinational
// ROM and the IF/ID pipeline register feeding decode.
module if_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_misalign
);

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        redirect, misalign;

    assign pc_plus4 = pc_q + 32'd4;

    next_pc_sel u_next_pc_sel (
        .pc_i         (pc_q),
        .pc_plus4_i   (pc_plus4),
        .stall_i      (stall),
        .br_taken_i   (br_taken),
        .br_target_i  (br_target),
        .jmp_i        (jmp),
        .jmp_target_i (jmp_target),
        .jr_i         (jr),
        .jr_target_i  (jr_target),
        .exc_i        (exc),
        .next_pc_o    (pc_d),
        .redirect_o   (redirect),
        .misalign_o   (misalign)
    );

    // if_id_valid qualifies the IF/ID payload: decode consumes it only when
    // high, and a held (stalled) entry is presented again unchanged.
    always_comb begin
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush || redirect) begin
            inst_d  = NOP_INST;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (!stall) begin
            inst_d  = imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr      = pc_q;
    assign if_id_inst     = inst_q;
    assign if_id_pc_plus4 = pc4_q;
    assign if_id_valid    = valid_q;
    assign fetch_misalign = misalign && reset;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle expected outputs are queued by the
// driver and compared by an independent monitor on the falling edge.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, br_taken, jmp, jr, exc;
    logic [31:0] br_target, jmp_target, jr_target;
    logic [31:0] imem_addr, imem_data, if_id_inst, if_id_pc_plus4;
    logic        if_id_valid, fetch_misalign;

    int total = 0;
    int bad   = 0;

    // {addr, valid, inst, pc_plus4, misalign}
    logic [97:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a >= 32'h0000_1000) return 32'h8000_0000;
        if (a == 32'h0)         return 32'h3C08_00FF;
        return 32'h2408_0000 | a;
    endfunction

    assign imem_data = rom_word(imem_addr);

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .jmp            (jmp),
        .jmp_target     (jmp_target),
        .jr             (jr),
        .jr_target      (jr_target),
        .exc            (exc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_id_inst     (if_id_inst),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fetch_misalign (fetch_misalign)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input logic [31:0] addr, input logic valid,
                                input logic [31:0] inst, input logic [31:0] pc4,
                                input logic mis);
        exp_q.push_back({addr, valid, inst, pc4, mis});
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    int cyc = 0;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [97:0] e;
            e = exp_q.pop_front();
            cyc++;
            check32($sformatf("imem_addr[c%0d]", cyc), imem_addr, e[97:66]);
            check32($sformatf("if_id_valid[c%0d]", cyc), {31'h0, if_id_valid}, {31'h0, e[65]});
            check32($sformatf("if_id_inst[c%0d]", cyc), if_id_inst, e[64:33]);
            check32($sformatf("if_id_pc_plus4[c%0d]", cyc), if_id_pc_plus4, e[32:1]);
            check32($sformatf("fetch_misalign[c%0d]", cyc), {31'h0, fetch_misalign}, {31'h0, e[0]});
        end
    end

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; exc = 1'b0;
        br_taken = 1'b0; jmp = 1'b0; jr = 1'b0;
        br_target = 32'h0; jmp_target = 32'h0; jr_target = 32'h0;

        // reset, then free run from 0
        tick();                       expect_cycle(32'h00, 0, 32'h0, 32'h00, 0);
        tick(); reset = 1'b1;         expect_cycle(32'h00, 0, 32'h0, 32'h00, 0);
        tick();                       expect_cycle(32'h04, 1, 32'h3C08_00FF, 32'h04, 0);
        tick();                       expect_cycle(32'h08, 1, 32'h2408_0004, 32'h08, 0);
        tick();                       expect_cycle(32'h0C, 1, 32'h2408_0008, 32'h0C, 0);
        // stall three cycles at PC 0x10
        tick(); stall = 1'b1;         expect_cycle(32'h10, 1, 32'h2408_000C, 32'h10, 0);
        tick();                       expect_cycle(32'h10, 1, 32'h2408_000C, 32'h10, 0);
        tick();                       expect_cycle(32'h10, 1, 32'h2408_000C, 32'h10, 0);
        tick(); stall = 1'b0;         expect_cycle(32'h10, 1, 32'h2408_000C, 32'h10, 0);
        tick();                       expect_cycle(32'h14, 1, 32'h2408_0010, 32'h14, 0);
        tick();                       expect_cycle(32'h18, 1, 32'h2408_0014, 32'h18, 0);
        tick();                       expect_cycle(32'h1C, 1, 32'h2408_0018, 32'h1C, 0);
        tick();                       expect_cycle(32'h20, 1, 32'h2408_001C, 32'h20, 0);
        // jump at PC 0x24 back to 0x1C
        tick(); jmp = 1'b1; jmp_target = 32'h1C;
                                      expect_cycle(32'h24, 1, 32'h2408_0020, 32'h24, 0);
        tick(); jmp = 1'b0;           expect_cycle(32'h1C, 0, 32'h0, 32'h00, 0);
        tick();                       expect_cycle(32'h20, 1, 32'h2408_001C, 32'h20, 0);
        // branch beats jump and stall; then exception beats everything
        tick(); br_taken = 1'b1; br_target = 32'h28; jmp = 1'b1; stall = 1'b1;
                                      expect_cycle(32'h24, 1, 32'h2408_0020, 32'h24, 0);
        tick(); exc = 1'b1;           expect_cycle(32'h28, 0, 32'h0, 32'h00, 0);
        tick(); exc = 1'b0; br_taken = 1'b0; jmp = 1'b0; stall = 1'b0;
                                      expect_cycle(32'h80, 0, 32'h0, 32'h00, 0);
        tick();                       expect_cycle(32'h84, 1, 32'h2408_0080, 32'h84, 0);
        // misaligned register jump traps to the exception vector
        tick(); jr = 1'b1; jr_target = 32'h5E;
                                      expect_cycle(32'h88, 1, 32'h2408_0084, 32'h88, 1);
        tick(); jr = 1'b0;            expect_cycle(32'h80, 0, 32'h0, 32'h00, 0);
        tick();                       expect_cycle(32'h84, 1, 32'h2408_0080, 32'h84, 0);
        // flush with stall: bubble, PC holds, nothing lost
        tick(); flush = 1'b1; stall = 1'b1;
                                      expect_cycle(32'h88, 1, 32'h2408_0084, 32'h88, 0);
        tick(); flush = 1'b0; stall = 1'b0;
                                      expect_cycle(32'h88, 0, 32'h0, 32'h00, 0);
        tick(); jmp = 1'b1; jmp_target = 32'h2C;
                                      expect_cycle(32'h8C, 1, 32'h2408_0088, 32'h8C, 0);
        // reset while stalled at 0x30 with a live IF/ID entry
        tick(); jmp = 1'b0;           expect_cycle(32'h2C, 0, 32'h0, 32'h00, 0);
        tick(); stall = 1'b1;         expect_cycle(32'h30, 1, 32'h2408_002C, 32'h30, 0);
        tick(); reset = 1'b0;         expect_cycle(32'h30, 1, 32'h2408_002C, 32'h30, 0);
        tick(); reset = 1'b1; stall = 1'b0;
                                      expect_cycle(32'h00, 0, 32'h0, 32'h00, 0);
        // misaligned branch target
        tick(); br_taken = 1'b1; br_target = 32'h41;
                                      expect_cycle(32'h04, 1, 32'h3C08_00FF, 32'h04, 1);
        // PC wrap at the top of the address space; ROM returns out-of-range word
        tick(); br_taken = 1'b0; jr = 1'b1; jr_target = 32'hFFFF_FFFC;
                                      expect_cycle(32'h80, 0, 32'h0, 32'h00, 0);
        tick(); jr = 1'b0;            expect_cycle(32'hFFFF_FFFC, 0, 32'h0, 32'h00, 0);
        tick();                       expect_cycle(32'h00, 1, 32'h8000_0000, 32'h00, 0);
        // exception masks a misaligned jr: no misalign pulse
        tick(); exc = 1'b1; jr = 1'b1; jr_target = 32'h5E;
                                      expect_cycle(32'h04, 1, 32'h3C08_00FF, 32'h04, 0);
        tick(); exc = 1'b0; jr = 1'b0; expect_cycle(32'h80, 0, 32'h0, 32'h00, 0);
        tick();                       expect_cycle(32'h84, 1, 32'h2408_0080, 32'h84, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined MIPS core. Holds the program counter, drives the word-aligned fetch address into the combinational instruction ROM, selects the next PC from sequential, branch, jump, register-jump and exception sources, and registers the fetched word into the IF/ID pipeline register. Directly upstream of the decode stage; the only producer of instruction-memory addresses.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- EXC_VECTOR, 32'h0000_0080, PC loaded on exception or misaligned redirect
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- stall  in  1  hazard hold from decode: freeze PC and IF/ID
- flush  in  1  squash the IF/ID contents (bubble) at next edge
- br_taken  in  1  branch resolved taken (from EX)
- br_target  in  32  branch target address
- jmp  in  1  j/jal in ID
- jmp_target  in  32  {pc_plus4[31:28], instr_index, 2'b00}
- jr  in  1  jr/jalr in ID
- jr_target  in  32  forwarded rs value
- exc  in  1  exception request
- imem_addr  out  32  fetch address to ROM (= current PC)
- imem_data  in  32  instruction word from ROM, same cycle
- if_id_inst  out  32  registered instruction
- if_id_pc_plus4  out  32  registered PC+4 of that instruction
- if_id_valid  out  1  registered instruction is live
- fetch_misalign  out  1  one-cycle pulse: redirect target had [1:0] != 0

## Operation
- Next-PC priority (highest first): exc -> EXC_VECTOR; br_taken -> br_target; jr -> jr_target; jmp -> jmp_target; stall -> PC unchanged; else PC+4.
- Any selected redirect target with bits [1:0] != 0: PC <= EXC_VECTOR, fetch_misalign = 1 for that cycle, IF/ID bubbled.
- Redirect (exc, br_taken, jr, jmp) overrides stall for the PC; the instruction currently fetched is wrong-path, so IF/ID loads a bubble.
- IF/ID update: reset, flush, or any redirect -> inst 32'h0000_0000, pc_plus4 32'h0, valid 0; else stall -> hold all three; else load imem_data, PC+4, valid 1.
- PC+4 is modulo 2^32: PC 32'hFFFF_FFFC wraps to 0.
- imem_data is used as returned; an out-of-range word (32'h8000_0000 from ROM) is passed through unmodified, decode handles it.
- imem_addr is combinational from the PC register only; no path from redirect inputs to imem_addr in the same cycle.

## Timing
- Reset (reset=0 at edge): PC=RESET_PC, if_id_inst=0, if_id_pc_plus4=0, if_id_valid=0, fetch_misalign=0. reset low mid-operation discards everything on that edge.
- Fetch latency: word at PC appears on if_id_inst one edge after PC is presented.
- Redirect asserted in cycle n: imem_addr = target in cycle n+1; if_id_valid=0 in cycle n+1; target instruction valid in ID in cycle n+2.
- stall held k cycles with no redirect: PC and IF/ID constant k cycles, resume next cycle without loss or duplication.
- flush with stall and no redirect: IF/ID bubbles, PC holds.
- fetch_misalign is combinational with the redirect and deasserts when the redirect input drops.

## Structure
- Shared package cpu_pkg: RESET_PC, EXC_VECTOR, NOP_INST (32'h0), next-PC select enum {PC_SEQ, PC_HOLD, PC_BR, PC_JR, PC_JMP, PC_EXC}.
- One combinational sub-module next_pc_sel: priority encode, alignment check, produce next_pc and redirect flag; if_stage holds PC and IF/ID registers.
- Target RTL size ~150-250 lines.

## Test plan
- Reset then 4 free cycles with ROM model -> imem_addr 0,4,8,C; if_id_inst word0 (32'h3C08_00FF) valid one cycle after addr 0.
- jmp=1, jmp_target=32'h1C at PC=32'h24 -> next imem_addr 32'h1C, if_id_valid=0 that cycle, then word7 at ID with pc_plus4=32'h20.
- stall held 3 cycles at PC=32'h10 -> imem_addr 32'h10 and if_id_inst unchanged 3 cycles, then 32'h14.
- br_taken and jmp and stall together, br_target=32'h28 -> PC 32'h28 (branch wins), bubble in IF/ID; with exc also high -> PC 32'h80.
- jr=1, jr_target=32'h5E -> fetch_misalign=1 for one cycle, PC=32'h80, bubble.
- reset low while stalled at PC=32'h30 with valid IF/ID -> PC=0, if_id_valid=0 next edge; PC=32'hFFFF_FFFC free-run -> wraps to 0.
